bus_arb_mux: RTL and testbench

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

---
 rtl/bus_arb_mux.sv | 128 ++++++++++++
 tb/tb_bus_arb_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arb_mux.sv
// Bus arbiter and source multiplexer.
// Picks one requesting source per cycle using either fixed priority or
// round-robin. It registers that source's data onto the bus along with a
// one-hot grant and its binary index. It also flags and counts cycles in
// which more than one source requested the bus. An optional lock input
// keeps the current owner on the bus for as long as it keeps requesting.
module bus_arb_mux #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 24,
  parameter int RR_MODE = 0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_req,
  input  logic                    lock,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [NSRC-1:0]         grant,
  output logic [$clog2(NSRC)-1:0] grant_idx,
  output logic                    conflict,
  output logic [15:0]             conflict_cnt
);

  localparam int IW = $clog2(NSRC);

  logic [WIDTH-1:0] bus_q,      bus_d;
  logic             valid_q,    valid_d;
  logic [NSRC-1:0]  grant_q,    grant_d;
  logic [IW-1:0]    idx_q,      idx_d;
  logic             conflict_q, conflict_d;
  logic [15:0]      cnt_q,      cnt_d;
  logic [IW-1:0]    rr_ptr_q,   rr_ptr_d;

  logic             hold;
  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    sel_idx;
  int               start;
  int               j;
  int               nreq;

  // Winner search: scan upward from the start point with wrap-around.
  // Fixed priority always starts at source 0; round-robin starts at rr_ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    start = (RR_MODE != 0) ? int'(rr_ptr_q) : 0;
    for (int k = 0; k < NSRC; k++) begin
      j = (start + k) % NSRC;
      if (!found && src_req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // Count the sampled requests. Contention is judged on the raw request
  // vector, so it is still reported while a lock hold is in force.
  always_comb begin
    nreq = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_req[i]) nreq++;
    end
  end

  // The lock only holds when a valid owner exists and it is still
  // requesting. A dropped request releases the hold in the same cycle.
  assign hold = lock && valid_q && src_req[idx_q];

  // Next-state selection: hold the owner, grant a new winner, or go idle.
  // rr_ptr only advances when a new grant is made.
  always_comb begin
    bus_d      = '0;
    valid_d    = 1'b0;
    grant_d    = '0;
    idx_d      = '0;
    rr_ptr_d   = rr_ptr_q;
    sel_idx    = hold ? idx_q : win;
    conflict_d = (nreq >= 2);
    cnt_d      = cnt_q;
    if (hold) begin
      bus_d   = src_data[int'(sel_idx)*WIDTH +: WIDTH];
      valid_d = 1'b1;
      grant_d = grant_q;
      idx_d   = idx_q;
    end else if (found) begin
      bus_d          = src_data[int'(sel_idx)*WIDTH +: WIDTH];
      valid_d        = 1'b1;
      grant_d[win]   = 1'b1;
      idx_d          = win;
      rr_ptr_d       = (win == IW'(NSRC - 1)) ? '0 : win + 1'b1;
    end
    if (conflict_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State register with synchronous clear that overrides any hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      grant_q    <= '0;
      idx_q      <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      bus_q      <= bus_d;
      valid_q    <= valid_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus_out      = bus_q;
  assign bus_valid    = valid_q;
  assign grant        = grant_q;
  assign grant_idx    = idx_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Scoreboard bench for bus_arb_mux.
// It drives two instances: the default fixed-priority one (24 sources) and a
// 4-source round-robin one. Each stimulus vector pushes its hand-computed
// response into a queue. A monitor per instance pops and compares that
// response one cycle later.
module tb_bus_arb_mux;

  logic clk;

  // Fixed-priority instance, default parameters
  logic            clr0;
  logic [24*32-1:0] data0;
  logic [23:0]     req0;
  logic            lock0;
  logic [31:0]     bus0;
  logic            valid0;
  logic [23:0]     grant0;
  logic [4:0]      idx0;
  logic            conf0;
  logic [15:0]     cnt0;

  // Round-robin instance, 4 sources
  logic            clr1;
  logic [4*32-1:0] data1;
  logic [3:0]      req1;
  logic            lock1;
  logic [31:0]     bus1;
  logic            valid1;
  logic [3:0]      grant1;
  logic [1:0]      idx1;
  logic            conf1;
  logic [15:0]     cnt1;

  logic [31:0] dat0 [24];
  logic [31:0] dat1 [4];

  typedef struct {
    logic [31:0] bus;
    logic        valid;
    logic [31:0] grant;
    logic [4:0]  idx;
    logic        conf;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0;
  int miscompares = 0;

  bus_arb_mux dut0 (
    .clk(clk), .clr(clr0), .src_data(data0), .src_req(req0), .lock(lock0),
    .bus_out(bus0), .bus_valid(valid0), .grant(grant0), .grant_idx(idx0),
    .conflict(conf0), .conflict_cnt(cnt0)
  );

  bus_arb_mux #(.WIDTH(32), .NSRC(4), .RR_MODE(1)) dut1 (
    .clk(clk), .clr(clr1), .src_data(data1), .src_req(req1), .lock(lock1),
    .bus_out(bus1), .bus_valid(valid1), .grant(grant1), .grant_idx(idx1),
    .conflict(conf1), .conflict_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on an instance and queue its expected response.
  task automatic applyStimulus(input int inst, input bit c, input bit lk,
                               input logic [31:0] req, input bit ev,
                               input int eidx, input bit ec, input int ecnt,
                               input string nm);
    exp_t e;
    @(negedge clk);
    e.valid = ev;
    e.idx   = ev ? 5'(eidx) : 5'd0;
    e.grant = ev ? (32'd1 << eidx) : 32'd0;
    e.conf  = ec;
    e.cnt   = 16'(ecnt);
    e.name  = nm;
    if (inst == 0) begin
      for (int i = 0; i < 24; i++) data0[i*32 +: 32] = dat0[i];
      clr0  = c;
      lock0 = lk;
      req0  = req[23:0];
      e.bus = ev ? dat0[eidx] : 32'd0;
      q0.push_back(e);
    end else begin
      for (int i = 0; i < 4; i++) data1[i*32 +: 32] = dat1[i];
      clr1  = c;
      lock1 = lk;
      req1  = req[3:0];
      e.bus = ev ? dat1[eidx] : 32'd0;
      q1.push_back(e);
    end
  endtask

  // Compare one observed response against its queued expectation.
  task automatic checkOutput(input int inst, input exp_t e, input logic [31:0] aBus,
                             input logic aValid, input logic [31:0] aGrant,
                             input logic [4:0] aIdx, input logic aConf,
                             input logic [15:0] aCnt);
    vectors++;
    if (aBus !== e.bus || aValid !== e.valid || aGrant !== e.grant ||
        aIdx !== e.idx || aConf !== e.conf || aCnt !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL dut%0d %s: got bus=%h valid=%b grant=%h idx=%0d conflict=%b cnt=%h, want bus=%h valid=%b grant=%h idx=%0d conflict=%b cnt=%h",
               inst, e.name, aBus, aValid, aGrant, aIdx, aConf, aCnt,
               e.bus, e.valid, e.grant, e.idx, e.conf, e.cnt);
    end
  endtask

  // Monitor for the fixed-priority instance.
  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      checkOutput(0, e, bus0, valid0, {8'd0, grant0}, idx0, conf0, cnt0);
    end
  end

  // Monitor for the round-robin instance.
  always begin
    @(posedge clk);
    #1;
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      checkOutput(1, e, bus1, valid1, {28'd0, grant1}, {3'd0, idx1}, conf1, cnt1);
    end
  end

  // Directed sequences for both instances.
  initial begin
    int ecnt;
    int waited;
    clr0 = 1'b1; lock0 = 1'b0; req0 = '0; data0 = '0;
    clr1 = 1'b1; lock1 = 1'b0; req1 = '0; data1 = '0;
    for (int i = 0; i < 24; i++) dat0[i] = 32'hC0DE_0000 | 32'(i);
    for (int i = 0; i < 4; i++)  dat1[i] = 32'h1000_0000 + 32'(i);

    // Fixed priority
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 0, 0, "reset");
    dat0[3] = 32'hAAAA0003;
    dat0[7] = 32'h0000_0007;
    applyStimulus(0, 0, 0, 32'h88, 1, 3, 1, 1, "fixed_3_vs_7");
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 1, "idle_after_grant");
    applyStimulus(0, 0, 0, 32'h20, 1, 5, 0, 1, "grant_src5");
    dat0[5] = 32'h5555_0001;
    applyStimulus(0, 0, 1, 32'h24, 1, 5, 1, 2, "lock_hold_5");
    dat0[5] = 32'h5555_0002;
    applyStimulus(0, 0, 1, 32'h24, 1, 5, 1, 3, "lock_hold_new_data");
    applyStimulus(0, 0, 1, 32'h04, 1, 2, 0, 3, "lock_release_to_2");
    applyStimulus(0, 0, 0, 32'h80_0000, 1, 23, 0, 3, "top_source_23");
    applyStimulus(0, 0, 0, 32'hFF_FFFF, 1, 0, 1, 4, "all_request");
    ecnt = 4;
    for (int k = 0; k < 70000; k++) begin
      ecnt = (ecnt < 65535) ? ecnt + 1 : 65535;
      applyStimulus(0, 0, 0, 32'h3, 1, 0, 1, ecnt, "saturate");
    end
    applyStimulus(0, 0, 0, 32'h2, 1, 1, 0, 65535, "after_saturation");
    applyStimulus(0, 1, 1, 32'h3, 0, 0, 0, 0, "reset_clears_count");

    // Round-robin
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 0, 0, "rr_reset");
    applyStimulus(1, 0, 0, 32'hF, 1, 0, 1, 1, "rr_seq0");
    applyStimulus(1, 0, 0, 32'hF, 1, 1, 1, 2, "rr_seq1");
    applyStimulus(1, 0, 0, 32'hF, 1, 2, 1, 3, "rr_seq2");
    applyStimulus(1, 0, 0, 32'hF, 1, 3, 1, 4, "rr_seq3");
    applyStimulus(1, 0, 0, 32'hF, 1, 0, 1, 5, "rr_seq_wrap");
    applyStimulus(1, 0, 0, 32'h4, 1, 2, 0, 5, "rr_from_ptr1");
    applyStimulus(1, 0, 1, 32'hC, 1, 2, 1, 6, "rr_lock_hold");
    applyStimulus(1, 1, 1, 32'hC, 0, 0, 0, 0, "rr_reset_mid_hold");
    applyStimulus(1, 0, 0, 32'h9, 1, 0, 1, 1, "rr_ptr_restart");
    applyStimulus(1, 0, 1, 32'hF, 1, 0, 1, 2, "rr_hold_again");
    applyStimulus(1, 1, 1, 32'hF, 0, 0, 0, 0, "rr_reset_hold2");
    applyStimulus(1, 0, 1, 32'h8, 1, 3, 0, 0, "rr_after_reset_3");
    applyStimulus(1, 0, 0, 32'hF, 1, 0, 1, 1, "rr_ptr_wrapped");

    @(negedge clk);
    clr0 = 1'b1;
    clr1 = 1'b1;
    waited = 0;
    while ((q0.size() > 0 || q1.size() > 0) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending responses, want 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
